// File: rtl/snitch_icache_pkg.sv
// snitch_icache_pkg
//   Shared types and helpers for the icache refill path.
//   - refill_req_t   : refill request (line address + pending-table ID)
//   - refill_state_e : response FSM states of the line refill engine
//   - refill_beats() : number of memory beats per cache line
//   - refill_cfg_ok(): elaboration-time sanity check of the beat geometry
package snitch_icache_pkg;

    localparam int unsigned REFILL_AW = 32;
    localparam int unsigned REFILL_IW = 2;

    typedef struct packed {
        logic [REFILL_AW-1:0] addr;
        logic [REFILL_IW-1:0] id;
    } refill_req_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } refill_state_e;

    function automatic int unsigned refill_beats(input int unsigned line_width,
                                                 input int unsigned beat_width);
        return (beat_width == 0) ? 0 : line_width / beat_width;
    endfunction

    // Beats must divide the line exactly, be a power of two and fit the 8-bit len.
    function automatic bit refill_cfg_ok(input int unsigned line_width,
                                         input int unsigned beat_width);
        int unsigned beats;
        if (beat_width == 0) return 1'b0;
        if ((line_width % beat_width) != 0) return 1'b0;
        beats = line_width / beat_width;
        return (beats >= 1) && (beats <= 256) && ((beats & (beats - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3
//   Small synchronous FIFO (common_cells style interface, no fall-through).
//   Ports: clk_i, rst_ni (async low), flush_i, full_o, empty_o, usage_o,
//          data_i/push_i (write side), data_o/pop_i (read side).
//   data_o always shows the head entry; storage resets to zero so the head
//   reads 0 while the FIFO is empty after reset.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
    logic [ADDR_DEPTH:0]   cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] p);
        return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/snitch_icache_line_refill.sv
// snitch_icache_line_refill
//   Line refill engine below the icache miss handler. Each refill request is
//   forwarded combinationally as one line-aligned burst; returned beats are
//   packed into a line (beat 0 in the LSBs) and handed back in order with the
//   request's pending-table ID and a sticky OR of the beat errors.
//   Ports:
//     clk_i, rst_ni                      clock, async active-low reset
//     in_req_*                           refill request (addr, id, valid/ready)
//     out_rsp_*                          assembled line (data, error, id, valid/ready)
//     mem_req_*                          burst request (addr, len = BEATS-1, valid/ready)
//     mem_rsp_*                          beat return (data, error, last, valid/ready)
//     perf_refills_o, perf_stall_o       only with SNITCH_ICACHE_REFILL_PERF_EN defined:
//                                        saturating counts of completed responses and
//                                        of cycles the response is held off
module snitch_icache_line_refill
    import snitch_icache_pkg::*;
#(
    parameter int unsigned FETCH_AW   = 32,
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned BEAT_WIDTH = 64,
    parameter int unsigned PENDING_IW = 2,
    parameter int unsigned ID_DEPTH   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [FETCH_AW-1:0]   in_req_addr_i,
    input  logic [PENDING_IW-1:0] in_req_id_i,
    input  logic                  in_req_valid_i,
    output logic                  in_req_ready_o,
    output logic [LINE_WIDTH-1:0] out_rsp_data_o,
    output logic                  out_rsp_error_o,
    output logic [PENDING_IW-1:0] out_rsp_id_o,
    output logic                  out_rsp_valid_o,
    input  logic                  out_rsp_ready_i,
    output logic [FETCH_AW-1:0]   mem_req_addr_o,
    output logic [7:0]            mem_req_len_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    input  logic [BEAT_WIDTH-1:0] mem_rsp_data_i,
    input  logic                  mem_rsp_error_i,
    input  logic                  mem_rsp_last_i,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o
`ifdef SNITCH_ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]           perf_refills_o,
    output logic [31:0]           perf_stall_o
`endif
);

    localparam int unsigned BEATS    = refill_beats(LINE_WIDTH, BEAT_WIDTH);
    localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFFSET_W = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(BEATS - 1);
    localparam logic [FETCH_AW-1:0] ADDR_MASK = ~((FETCH_AW'(1) << OFFSET_W) - FETCH_AW'(1));

    if (!refill_cfg_ok(LINE_WIDTH, BEAT_WIDTH)) begin : gen_bad_cfg
        $error("LINE_WIDTH/BEAT_WIDTH must be a power of two between 1 and 256");
    end
    if (ID_DEPTH < 1) begin : gen_bad_depth
        $error("ID_DEPTH must be at least 1");
    end

    refill_state_e         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic                  err_q;
    logic                  id_full, id_empty, id_push, id_pop;
    logic                  beat_hs, rsp_hs;

    // Request path: purely combinational; the ID FIFO bounds refills in flight.
    assign mem_req_valid_o = in_req_valid_i && !id_full;
    assign in_req_ready_o  = mem_req_ready_i && !id_full;
    assign mem_req_addr_o  = in_req_addr_i & ADDR_MASK;
    assign mem_req_len_o   = 8'(BEATS - 1);
    assign id_push         = in_req_valid_i && in_req_ready_o;

    assign beat_hs = mem_rsp_valid_i && mem_rsp_ready_o;
    assign rsp_hs  = out_rsp_valid_o && out_rsp_ready_i;
    assign id_pop  = rsp_hs;

    // Push is gated by full_o even when a pop happens in the same cycle.
    fifo_v3 #(
        .DATA_WIDTH (PENDING_IW),
        .DEPTH      (ID_DEPTH)
    ) i_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (id_full),
        .empty_o (id_empty),
        .usage_o (),
        .data_i  (in_req_id_i),
        .push_i  (id_push),
        .data_o  (out_rsp_id_o),
        .pop_i   (id_pop)
    );

    always_comb begin
        state_d         = state_q;
        mem_rsp_ready_o = 1'b0;
        out_rsp_valid_o = 1'b0;
        unique case (state_q)
            FILL: begin
                mem_rsp_ready_o = 1'b1;
                if (mem_rsp_valid_i && (cnt_q == CNT_LAST)) state_d = HOLD;
            end
            HOLD: begin
                out_rsp_valid_o = 1'b1;
                if (out_rsp_ready_i) state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    // Line and error are only written in FILL, so they stay frozen through HOLD.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
            cnt_q   <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (beat_hs) begin
                for (int unsigned b = 0; b < BEATS; b++) begin
                    if (cnt_q == CNT_W'(b)) line_q[b*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rsp_data_i;
                end
                err_q <= err_q | mem_rsp_error_i;
                cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end else if (rsp_hs) begin
                err_q <= 1'b0;
            end
        end
    end

    assign out_rsp_data_o  = line_q;
    assign out_rsp_error_o = err_q;

`ifdef SNITCH_ICACHE_REFILL_PERF_EN
    logic [31:0] perf_refills_q, perf_stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_refills_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (rsp_hs && (perf_refills_q != '1)) perf_refills_q <= perf_refills_q + 1'b1;
            if (out_rsp_valid_o && !out_rsp_ready_i && (perf_stall_q != '1))
                perf_stall_q <= perf_stall_q + 1'b1;
        end
    end

    assign perf_refills_o = perf_refills_q;
    assign perf_stall_o   = perf_stall_q;
`endif

`ifndef SYNTHESIS
    a_beat_without_id : assert property (@(posedge clk_i) disable iff (!rst_ni)
        beat_hs |-> !id_empty)
        else $error("refill beat accepted with no outstanding ID");
    a_last_mismatch : assert property (@(posedge clk_i) disable iff (!rst_ni)
        beat_hs |-> (mem_rsp_last_i == (cnt_q == CNT_LAST)))
        else $error("mem_rsp_last_i does not match beat position");
    a_rsp_valid_drop : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_rsp_valid_o && !out_rsp_ready_i) |=> out_rsp_valid_o)
        else $error("out_rsp_valid_o dropped before handshake");
`endif

endmodule
